// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo
//
// Multi-cycle control FSM for the core.
// - Fetches an instruction word and decodes its opcode/funct fields.
// - Drives the ALU operation and sub-operation.
// - Resolves branches and jumps from the ALU Zero flag.
// - Sequences the memory, register-file and I/O handshakes.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   Instrucao[31:0]     instruction register contents (opcode [31:26], funct [5:0])
//   Zero                ALU branch-taken flag, only consulted in EXECUTA
//   Mem_pronta          memory finishes the current access this cycle
//   Entrada_valida      input device has a word available
//   Saida_pronta        output device accepts the word this cycle
//   Opcode, OpALU       ALU operation (identical values)
//   funct               ALU sub-operation
//   EscreveIR, EscrevePC, LeMem, EscreveMem, EscreveReg   strobes
//   FontePC             0 = PC+1, 1 = immediate target, 2 = register (JR)
//   FonteDadoReg        0 = ALU result, 1 = memory, 2 = input device
//   FonteB              ALU operand B: 0 = register, 1 = immediate
//   Saida_valida        output word valid
//   Parado              core halted
//   Estado              current state code, for debug
module unidade_controle_multiciclo #(
  parameter logic [5:0] OPC_PARADA = 6'd63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instrucao,
  input  logic        Zero,
  input  logic        Mem_pronta,
  input  logic        Entrada_valida,
  input  logic        Saida_pronta,
  output logic [5:0]  Opcode,
  output logic [5:0]  OpALU,
  output logic [5:0]  funct,
  output logic        EscreveIR,
  output logic        EscrevePC,
  output logic        LeMem,
  output logic        EscreveMem,
  output logic        EscreveReg,
  output logic [1:0]  FontePC,
  output logic [1:0]  FonteDadoReg,
  output logic        FonteB,
  output logic        Saida_valida,
  output logic        Parado,
  output logic [2:0]  Estado
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    ESPERA_ES  = 3'd5,
    PARADO     = 3'd6
  } estado_t;

  estado_t     estado;
  logic [5:0]  op_reg;
  logic [1:0]  fonte_dado_reg;
  logic [5:0]  op_inst;
  logic        eh_alu, eh_load, eh_store, eh_desvio, eh_in, eh_out;
  logic        usa_imediato, op_indefinido;
  logic        unused_bits;

  assign op_inst     = Instrucao[31:26];
  // The middle of the instruction word belongs to the datapath, not to us.
  assign unused_bits = ^Instrucao[25:6];

  // Instruction classes are taken from the opcode latched in DECODIFICA, so
  // the sequencing after decode depends only on that snapshot.
  assign eh_alu    = op_reg inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd13,
                                    [6'd15:6'd18], 6'd20};
  assign eh_load   = op_reg inside {6'd6, 6'd31};
  assign eh_store  = op_reg inside {6'd7, 6'd30};
  assign eh_desvio = op_reg inside {6'd5, 6'd10, 6'd11, 6'd19};
  assign eh_in     = (op_reg == 6'd8);
  assign eh_out    = (op_reg == 6'd9);

  assign op_indefinido = op_inst inside {6'd12, 6'd14, [6'd21:6'd29], [6'd32:6'd62]};
  assign usa_imediato  = op_inst inside {6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd20, 6'd30, 6'd31};

  // State register plus the write-back source remembered from the path that
  // led into ESCRITA. Every wait state simply holds until its handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= BUSCA;
      op_reg         <= 6'd0;
      fonte_dado_reg <= 2'd0;
    end else begin
      case (estado)
        BUSCA: begin
          if (Mem_pronta) estado <= DECODIFICA;
        end
        DECODIFICA: begin
          op_reg <= op_inst;
          if (op_inst == OPC_PARADA)  estado <= PARADO;
          else if (op_indefinido)     estado <= BUSCA;
          else                        estado <= EXECUTA;
        end
        EXECUTA: begin
          fonte_dado_reg <= 2'd0;
          if (eh_alu)                      estado <= ESCRITA;
          else if (eh_load || eh_store)    estado <= MEMORIA;
          else if (eh_in || eh_out)        estado <= ESPERA_ES;
          else                             estado <= BUSCA;
        end
        MEMORIA: begin
          if (Mem_pronta) begin
            if (eh_load) begin
              estado         <= ESCRITA;
              fonte_dado_reg <= 2'd1;
            end else begin
              estado <= BUSCA;
            end
          end
        end
        ESPERA_ES: begin
          if (eh_in && Entrada_valida) begin
            estado         <= ESCRITA;
            fonte_dado_reg <= 2'd2;
          end else if (eh_out && Saida_pronta) begin
            estado <= BUSCA;
          end
        end
        ESCRITA: estado <= BUSCA;
        PARADO:  estado <= PARADO;
        default: estado <= BUSCA;
      endcase
    end
  end

  // Output decode. The handshake strobes are Mealy on purpose: the IR/PC
  // write in BUSCA and the branch PC write follow the inputs in the same
  // cycle. Everything is forced to its idle value while reset is held, so
  // a memory write in flight is cut off immediately.
  always_comb begin
    Opcode       = 6'h3F;
    funct        = 6'h00;
    EscreveIR    = 1'b0;
    EscrevePC    = 1'b0;
    LeMem        = 1'b0;
    EscreveMem   = 1'b0;
    EscreveReg   = 1'b0;
    FontePC      = 2'd0;
    FonteDadoReg = 2'd0;
    FonteB       = 1'b0;
    Saida_valida = 1'b0;
    Parado       = 1'b0;
    Estado       = estado;
    if (!reset) begin
      if (estado inside {EXECUTA, MEMORIA, ESCRITA, ESPERA_ES}) begin
        Opcode = op_inst;
        funct  = Instrucao[5:0];
        FonteB = usa_imediato;
      end
      case (estado)
        BUSCA: begin
          LeMem = 1'b1;
          if (Mem_pronta) begin
            EscreveIR = 1'b1;
            EscrevePC = 1'b1;
          end
        end
        EXECUTA: begin
          if (eh_desvio) begin
            EscrevePC = Zero;
            FontePC   = (op_reg == 6'd19) ? 2'd2 : 2'd1;
          end
        end
        MEMORIA: begin
          LeMem      = eh_load;
          EscreveMem = eh_store;
        end
        ESPERA_ES: begin
          Saida_valida = eh_out;
        end
        ESCRITA: begin
          EscreveReg   = 1'b1;
          FonteDadoReg = fonte_dado_reg;
        end
        PARADO: begin
          Parado = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign OpALU = Opcode;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo
//
// Self-checking bench for the multi-cycle control unit. Instructions are
// described as a list of phases (fetch, decode, execute, memory, I/O wait,
// write-back, halt), expanded into a per-cycle queue of inputs and expected
// outputs, then replayed against the DUT.
module tb_unidade_controle_multiciclo;

  logic        clock;
  logic        reset;
  logic [31:0] Instrucao;
  logic        Zero, Mem_pronta, Entrada_valida, Saida_pronta;
  logic [5:0]  Opcode, OpALU, funct;
  logic        EscreveIR, EscrevePC, LeMem, EscreveMem, EscreveReg;
  logic [1:0]  FontePC, FonteDadoReg;
  logic        FonteB, Saida_valida, Parado;
  logic [2:0]  Estado;

  int checks   = 0;
  int failures = 0;

  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_LD   = 2;
  localparam int K_ST   = 3;
  localparam int K_IN   = 4;
  localparam int K_OUT  = 5;
  localparam int K_NOP  = 6;
  localparam int K_HALT = 7;

  typedef struct packed {
    logic [2:0] est;
    logic [5:0] opc;
    logic [5:0] opa;
    logic [5:0] fn;
    logic       ir, pc, le, em, er;
    logic [1:0] fpc, fdr;
    logic       fb, sv, par;
  } out_t;

  typedef struct {
    logic mp, ev, sp, z;
    out_t exp;
  } cyc_t;

  typedef struct {
    string      name;
    int         op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         hw;
    int         exp_len;
  } vec_t;

  cyc_t q[$];
  vec_t tbl[17];

  unidade_controle_multiciclo #(.OPC_PARADA(6'd63)) dut (
    .clock(clock), .reset(reset), .Instrucao(Instrucao), .Zero(Zero),
    .Mem_pronta(Mem_pronta), .Entrada_valida(Entrada_valida),
    .Saida_pronta(Saida_pronta), .Opcode(Opcode), .OpALU(OpALU),
    .funct(funct), .EscreveIR(EscreveIR), .EscrevePC(EscrevePC),
    .LeMem(LeMem), .EscreveMem(EscreveMem), .EscreveReg(EscreveReg),
    .FontePC(FontePC), .FonteDadoReg(FonteDadoReg), .FonteB(FonteB),
    .Saida_valida(Saida_valida), .Parado(Parado), .Estado(Estado)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the DUT or the bench gets stuck somewhere.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction classes straight from the opcode table.
  function automatic int kindOf(input int op);
    if (op inside {0, 1, 2, 3, 4, 13, [15:18], 20}) return K_ALU;
    if (op inside {5, 10, 11, 19})                   return K_BR;
    if (op inside {6, 31})                           return K_LD;
    if (op inside {7, 30})                           return K_ST;
    if (op == 8)                                     return K_IN;
    if (op == 9)                                     return K_OUT;
    if (op == 63)                                    return K_HALT;
    return K_NOP;
  endfunction

  function automatic logic fbOf(input int op);
    return op inside {2, 5, 6, 7, 8, 20, 30, 31};
  endfunction

  // Outputs of a state that does not expose the instruction to the ALU.
  function automatic out_t idleOut(input int est);
    out_t o;
    o     = '0;
    o.est = 3'(est);
    o.opc = 6'h3F;
    o.opa = 6'h3F;
    return o;
  endfunction

  // Outputs of a state that presents the instruction fields to the ALU.
  function automatic out_t activeOut(input int est, input int op, input logic [5:0] fn);
    out_t o;
    o     = '0;
    o.est = 3'(est);
    o.opc = 6'(op);
    o.opa = 6'(op);
    o.fn  = fn;
    o.fb  = fbOf(op);
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.est = Estado;       o.opc = Opcode;     o.opa = OpALU;
    o.fn  = funct;        o.ir  = EscreveIR;  o.pc  = EscrevePC;
    o.le  = LeMem;        o.em  = EscreveMem; o.er  = EscreveReg;
    o.fpc = FontePC;      o.fdr = FonteDadoReg;
    o.fb  = FonteB;       o.sv  = Saida_valida; o.par = Parado;
    return o;
  endfunction

  // Inputs that should not matter get random values, which also exercises
  // Zero being ignored outside execute and the unrelated I/O handshake.
  function automatic cyc_t randCycle();
    cyc_t c;
    c.mp  = 1'($urandom_range(0, 1));
    c.ev  = 1'($urandom_range(0, 1));
    c.sp  = 1'($urandom_range(0, 1));
    c.z   = 1'($urandom_range(0, 1));
    c.exp = '0;
    return c;
  endfunction

  // Reference model: expands one instruction into its cycles. fw is the
  // number of fetch wait cycles, hw the wait cycles of the memory or I/O
  // handshake.
  task automatic buildInstr(input int op, input logic [5:0] fn, input logic zero,
                            input int fw, input int hw);
    int   k;
    cyc_t c;
    k = kindOf(op);
    for (int i = 0; i <= fw; i++) begin
      c        = randCycle();
      c.mp     = (i == fw);
      c.exp    = idleOut(0);
      c.exp.le = 1'b1;
      if (i == fw) begin
        c.exp.ir = 1'b1;
        c.exp.pc = 1'b1;
      end
      q.push_back(c);
    end
    c     = randCycle();
    c.exp = idleOut(1);
    q.push_back(c);
    if (k == K_HALT) begin
      c         = randCycle();
      c.exp     = idleOut(6);
      c.exp.par = 1'b1;
      q.push_back(c);
      return;
    end
    if (k == K_NOP) return;
    c     = randCycle();
    c.z   = zero;
    c.exp = activeOut(2, op, fn);
    if (k == K_BR) begin
      c.exp.pc  = zero;
      c.exp.fpc = (op == 19) ? 2'd2 : 2'd1;
    end
    q.push_back(c);
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= hw; i++) begin
        c        = randCycle();
        c.mp     = (i == hw);
        c.exp    = activeOut(3, op, fn);
        c.exp.le = (k == K_LD);
        c.exp.em = (k == K_ST);
        q.push_back(c);
      end
    end
    if (k == K_IN || k == K_OUT) begin
      for (int i = 0; i <= hw; i++) begin
        c = randCycle();
        if (k == K_IN) c.ev = (i == hw);
        else           c.sp = (i == hw);
        c.exp    = activeOut(5, op, fn);
        c.exp.sv = (k == K_OUT);
        q.push_back(c);
      end
    end
    if (k == K_ALU || k == K_LD || k == K_IN) begin
      c         = randCycle();
      c.exp     = activeOut(4, op, fn);
      c.exp.er  = 1'b1;
      c.exp.fdr = (k == K_LD) ? 2'd1 : (k == K_IN) ? 2'd2 : 2'd0;
      q.push_back(c);
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    Mem_pronta     = c.mp;
    Entrada_valida = c.ev;
    Saida_pronta   = c.sp;
    Zero           = c.z;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t got;
    got = observed();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Replays the queued cycles: drive just after the rising edge, compare on
  // the falling edge. With exp_len >= 0 the DUT's return to BUSCA is then
  // measured and compared against the expected instruction latency.
  task automatic runQueue(input string name, input int exp_len);
    int n;
    int extra;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      applyStimulus(q[i]);
      @(negedge clock);
      checkOutput($sformatf("%s cyc%0d", name, i), q[i].exp);
      @(posedge clock);
      #1;
    end
    q.delete();
    if (exp_len >= 0) begin
      Mem_pronta = 1'b0;
      extra      = 0;
      @(negedge clock);
      while (Estado != 3'd0 && extra < 20) begin
        @(posedge clock);
        #1;
        extra++;
        @(negedge clock);
      end
      checkVal($sformatf("%s latency", name), 32'(n + extra), 32'(exp_len));
      @(posedge clock);
      #1;
    end
  endtask

  task automatic doReset();
    reset          = 1'b1;
    Mem_pronta     = 1'b0;
    Entrada_valida = 1'b0;
    Saida_pronta   = 1'b0;
    Zero           = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic runInstr(input string name, input int op, input logic [5:0] fn,
                          input logic zero, input int fw, input int hw, input int exp_len);
    Instrucao = {6'(op), 20'($urandom), fn};
    buildInstr(op, fn, zero, fw, hw);
    runQueue(name, exp_len);
  endtask

  // Main sequence: reset behaviour, directed table, reset mid-store, halt,
  // then a randomized back-to-back instruction stream.
  initial begin
    cyc_t c;
    out_t e;
    int   op;

    tbl[0]  = '{"add",     0,  6'd0,  1'b0, 0, 0, 4};
    tbl[1]  = '{"sub_w",   1,  6'h22, 1'b0, 1, 0, 5};
    tbl[2]  = '{"alu_imm", 2,  6'd5,  1'b0, 0, 0, 4};
    tbl[3]  = '{"alu20",   20, 6'd3,  1'b1, 0, 0, 4};
    tbl[4]  = '{"beq_t",   10, 6'd0,  1'b1, 0, 0, 3};
    tbl[5]  = '{"beq_nt",  10, 6'd0,  1'b0, 0, 0, 3};
    tbl[6]  = '{"b_imm",   5,  6'd0,  1'b1, 0, 0, 3};
    tbl[7]  = '{"jr",      19, 6'd0,  1'b1, 0, 0, 3};
    tbl[8]  = '{"bne_w",   11, 6'd0,  1'b0, 2, 0, 5};
    tbl[9]  = '{"load_w",  6,  6'd0,  1'b0, 0, 2, 7};
    tbl[10] = '{"load31",  31, 6'd0,  1'b0, 0, 0, 5};
    tbl[11] = '{"store",   7,  6'd0,  1'b0, 0, 0, 4};
    tbl[12] = '{"store_w", 30, 6'd0,  1'b0, 0, 3, 7};
    tbl[13] = '{"in_w",    8,  6'd0,  1'b0, 0, 1, 6};
    tbl[14] = '{"out_w",   9,  6'd0,  1'b0, 0, 4, 8};
    tbl[15] = '{"nop12",   12, 6'd0,  1'b0, 0, 0, 2};
    tbl[16] = '{"nop40",   40, 6'd0,  1'b1, 1, 0, 3};

    reset          = 1'b1;
    Instrucao      = 32'h0;
    Mem_pronta     = 1'b1;
    Entrada_valida = 1'b1;
    Saida_pronta   = 1'b1;
    Zero           = 1'b1;

    // Held in reset with every input high: everything idle.
    @(negedge clock);
    checkOutput("reset", idleOut(0));
    @(posedge clock);
    #1;
    reset      = 1'b0;
    Mem_pronta = 1'b0;
    e          = idleOut(0);
    e.le       = 1'b1;
    @(negedge clock);
    checkOutput("first fetch", e);
    @(posedge clock);
    #1;

    // Directed table, each row from a fresh reset.
    for (int i = 0; i < 17; i++) begin
      doReset();
      runInstr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].hw, tbl[i].exp_len);
    end

    // Reset pulsed while a store is waiting on memory.
    doReset();
    Instrucao = {6'd7, 20'h12345, 6'd9};
    buildInstr(7, 6'd9, 1'b0, 0, 3);
    void'(q.pop_back());
    void'(q.pop_back());
    void'(q.pop_back());
    runQueue("rststore", -1);
    Mem_pronta = 1'b0;
    e          = activeOut(3, 7, 6'd9);
    e.em       = 1'b1;
    @(negedge clock);
    checkOutput("rststore pre", e);
    #1 reset = 1'b1;
    #1 checkVal("rststore em", {28'd0, Estado, EscreveMem}, 32'd0);
    #1 reset = 1'b0;
    Mem_pronta = 1'b1;
    #1 checkVal("rststore fetch", {27'd0, Estado, LeMem, EscreveMem}, 32'b10);
    @(posedge clock);
    #1;
    Mem_pronta = 1'b0;
    @(negedge clock);
    checkVal("rststore after", {28'd0, Estado, EscreveMem}, 32'b0010);
    @(posedge clock);
    #1;

    // Halt is absorbing whatever the inputs do.
    doReset();
    runInstr("halt", 63, 6'd0, 1'b0, 0, 0, -1);
    e     = idleOut(6);
    e.par = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c    = randCycle();
      c.mp = 1'b1;
      applyStimulus(c);
      @(negedge clock);
      checkOutput($sformatf("halted%0d", i), e);
      @(posedge clock);
      #1;
    end
    doReset();
    Mem_pronta = 1'b0;
    e          = idleOut(0);
    e.le       = 1'b1;
    @(negedge clock);
    checkOutput("halt reset", e);
    @(posedge clock);
    #1;

    // Randomized back-to-back stream without resets in between.
    doReset();
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 62));
      runInstr($sformatf("rnd%0d op%0d", i, op), op, 6'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multi-cycle control FSM that drives the ALU and the rest of the datapath. It fetches an instruction word, decodes its opcode and funct fields, and presents them on the ALU's `Opcode`/`OpALU`/`funct` inputs. It consumes the ALU's `Zero` flag to resolve branches and jumps, and sequences the register file, the memory and I/O handshakes. It sits between the instruction/data memory port and the datapath muxes. The ALU and register file stay purely combinational/storage; all sequencing lives here.

## Interface
Parameters:
- `OPC_PARADA`, default 6'd63: opcode that halts the core.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state BUSCA and all outputs to reset values.
- `Instrucao`  in  32  instruction register contents. Opcode = [31:26], funct = [5:0].
- `Zero`  in  1  ALU branch-taken flag.
- `Mem_pronta`  in  1  memory completes the current access this cycle.
- `Entrada_valida`  in  1  input device has a word available.
- `Saida_pronta`  in  1  output device accepts the word this cycle.
- `Opcode`, `OpALU`  out  6  ALU operation (identical values).
- `funct`  out  6  ALU sub-operation.
- `EscreveIR`, `EscrevePC`, `LeMem`, `EscreveMem`, `EscreveReg`  out  1  write/read strobes.
- `FontePC`  out  2  0 = PC+1, 1 = immediate target, 2 = register (JR).
- `FonteDadoReg`  out  2  0 = ALU result, 1 = memory, 2 = input device.
- `FonteB`  out  1  ALU operand B: 0 = register, 1 = immediate.
- `Saida_valida`  out  1  output word valid.
- `Parado`  out  1  core halted.
- `Estado`  out  3  current state code, for debug.

## Operation
- States and codes: BUSCA 0, DECODIFICA 1, EXECUTA 2, MEMORIA 3, ESCRITA 4, ESPERA_ES 5, PARADO 6.
- **BUSCA:** `LeMem`=1 until `Mem_pronta`. In the `Mem_pronta` cycle, `EscreveIR`=1, `EscrevePC`=1 and `FontePC`=0, then go to DECODIFICA.
- **DECODIFICA:** single cycle.
  - Opcode equal to `OPC_PARADA` → PARADO.
  - Undefined opcodes (12, 14, 21–29, 32–62) are NOPs → BUSCA.
  - All other opcodes → EXECUTA.
- **`Opcode`/`funct` outputs:**
  - In EXECUTA, MEMORIA, ESCRITA and ESPERA_ES they equal `Instrucao[31:26]` and `Instrucao[5:0]`.
  - In every other state they are 6'h3F and 6'h00, so the ALU result is 0.
- **`FonteB`:** 1 for opcodes 2, 5, 6, 7, 8, 20, 30, 31; otherwise 0.
- **EXECUTA exits:**
  - Opcodes 0, 1, 2, 3, 4, 13, 15–18, 20 → ESCRITA.
  - Opcodes 6, 7, 30, 31 → MEMORIA.
  - Opcodes 8, 9 → ESPERA_ES.
  - Opcodes 5, 10, 11, 19 → BUSCA, with `EscrevePC`=`Zero` in this cycle (Mealy). `FontePC`=2 for opcode 19, otherwise 1.
- **MEMORIA:**
  - Loads (6, 31): `LeMem`=1 until `Mem_pronta`, then → ESCRITA with `FonteDadoReg`=1.
  - Stores (7, 30): `EscreveMem`=1 until `Mem_pronta`, then → BUSCA.
- **ESPERA_ES:**
  - IN (8) waits for `Entrada_valida`, then → ESCRITA with `FonteDadoReg`=2.
  - OUT (9) holds `Saida_valida`=1 until `Saida_pronta`, then → BUSCA.
- **ESCRITA:** `EscreveReg`=1 for exactly one cycle, with `FonteDadoReg` as set by the entry path (0 for ALU ops), then → BUSCA.
- **PARADO:** absorbing. `Parado`=1, all strobes 0. Left only via `reset`.
- The `Opcode` field is sampled only in DECODIFICA/EXECUTA. `Instrucao` must be stable from IR write until return to BUSCA.

## Timing
- **Reset values:** state BUSCA, `Estado`=0, `Opcode`=`OpALU`=6'h3F, `funct`=0. Every other output is 0 while `reset`=1. `LeMem` rises in the first cycle after deassertion.
- **Latency, `Mem_pronta` tied high:**
  - ALU op: 4 cycles.
  - Branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle on `Mem_pronta`, `Entrada_valida` or `Saida_pronta` adds exactly one cycle.
- **Handshakes:**
  - Strobes stay asserted continuously while waiting and drop the cycle after the completing edge.
  - `Saida_valida` never drops before `Saida_pronta`.
- **Simultaneous `Entrada_valida` and `Saida_pronta`:** only the one matching the current opcode matters.
- **`Zero`:** ignored outside EXECUTA.
- **Reset mid-operation, e.g. during MEMORIA with `EscreveMem`=1:** the strobe clears asynchronously. No write completes later.
- **Strobe exclusivity:** at most one of `LeMem`, `EscreveMem` or `EscreveReg` is high in any cycle.

## Test plan
- **ADD:** `Instrucao` opcode 0, funct 0, `Mem_pronta`=1 → `Estado` sequence 0,1,2,4,0. `Opcode`=0 and `funct`=0 in EXECUTA. `EscreveReg`=1 only in cycle 4, with `FonteDadoReg`=0.
- **BEQ:** opcode 10 with `Zero`=1 → `EscrevePC`=1, `FontePC`=1 in EXECUTA. Same instruction with `Zero`=0 → `EscrevePC`=0. Both return to BUSCA after 3 cycles.
- **LOAD with waits:** opcode 6, `Mem_pronta` low for 2 cycles in MEMORIA → `LeMem` high 3 cycles, then `EscreveReg`=1 with `FonteDadoReg`=1. Total 7 cycles.
- **OUT:** opcode 9, `Saida_pronta` asserted after 4 cycles → `Saida_valida` high exactly 5 cycles, no `EscreveReg`, then → BUSCA.
- **Reset and halt:** `reset` pulsed mid-STORE → `EscreveMem` drops in the same cycle and `Estado`=0. Opcode 63 → `Parado`=1 permanently, all strobes 0, `Opcode`=6'h3F.
